// File: rtl/prach_unreshape_ch.sv
// Inverse PRACH lane/channel corner-turn: per-half lane order in, per-channel-pair lane order out.
// Tracks frame position from sync_in, flags unexpected syncs and blanks the disturbed output window.
module prach_unreshape_ch #(
    parameter int SIZE       = 8,
    parameter int NUM_ACTIVE = SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dp1,
    input  logic [15:0] din_dp2,
    input  logic        din_dv,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dq1,
    output logic [15:0] dout_dq2,
    output logic        dout_dv,
    output logic [7:0]  dout_chn,
    output logic        sync_out,
    output logic        err_sync
);
    localparam int H     = SIZE / 2;
    localparam int POS_W = $clog2(SIZE);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [POS_W-1:0]    blank_q, blank_d;
    logic                err_q, err_d;
    logic [H-1:0][15:0]  d0_q, d0_d, d1_q, d1_d;
    logic [H-1:0]        dvp_q, dvp_d, syp_q, syp_d;
    logic [15:0]         dq1_q, dq1_d, dq2_q, dq2_d;
    logic                dv_q, dv_d, sync_q, sync_d;
    logic [7:0]          chn_q, chn_d;
    logic                lock_now, phase_b;
    logic                chn_unused;

    // Slot index is carried for debug only; sequencing comes from sync_in.
    assign chn_unused = ^din_chn;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        err_d   = 1'b0;
        blank_d = (blank_q != '0) ? blank_q - POS_W'(1) : '0;
        case (state_q)
            UNLOCKED: begin
                pos_d = '0;
                if (sync_in) state_d = LOCKED;
            end
            LOCKED: begin
                if (sync_in) begin
                    pos_d = '0;
                    if (pos_q != POS_W'(SIZE - 1)) begin
                        err_d   = 1'b1;
                        blank_d = POS_W'(H);
                    end
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        lock_now = (state_d == LOCKED);
        phase_b  = pos_d[POS_W-1];

        d0_d     = d0_q;
        d1_d     = d1_q;
        dvp_d    = dvp_q;
        syp_d    = syp_q;
        d0_d[0]  = din_dp2;
        // D1 takes lane 1 in phase A, then the delayed lane 2 in phase B.
        d1_d[0]  = phase_b ? d0_q[H-1] : din_dp1;
        dvp_d[0] = din_dv & lock_now;
        syp_d[0] = sync_in & lock_now;
        for (int i = 1; i < H; i++) begin
            d0_d[i]  = d0_q[i-1];
            d1_d[i]  = d1_q[i-1];
            dvp_d[i] = dvp_q[i-1];
            syp_d[i] = syp_q[i-1];
        end

        dq1_d  = d1_q[H-1];
        dq2_d  = phase_b ? din_dp1 : d0_q[H-1];
        // Output phase is the input phase rotated by half a frame.
        chn_d  = lock_now ? 8'(pos_d ^ POS_W'(H)) : 8'd0;
        dv_d   = dvp_q[H-1] & ({1'b0, chn_d} < 9'(NUM_ACTIVE)) & (blank_q == '0);
        sync_d = syp_q[H-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            pos_q   <= '0;
            blank_q <= '0;
            err_q   <= 1'b0;
            dvp_q   <= '0;
            syp_q   <= '0;
            dq1_q   <= '0;
            dq2_q   <= '0;
            dv_q    <= 1'b0;
            chn_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            dvp_q   <= dvp_d;
            syp_q   <= syp_d;
            dq1_q   <= dq1_d;
            dq2_q   <= dq2_d;
            dv_q    <= dv_d;
            chn_q   <= chn_d;
            sync_q  <= sync_d;
        end
    end

    always_ff @(posedge clk) begin
        d0_q <= d0_d;
        d1_q <= d1_d;
    end

    assign dout_dq1 = dq1_q;
    assign dout_dq2 = dq2_q;
    assign dout_dv  = dv_q;
    assign dout_chn = chn_q;
    assign sync_out = sync_q;
    assign err_sync = err_q;

endmodule

// File: tb/tb_prach_unreshape_ch.sv
// Directed bench for prach_unreshape_ch (SIZE=8, NUM_ACTIVE=6): lock, streaming, dv masking,
// unexpected sync with blanking, and mid-frame reset.
module tb_prach_unreshape_ch;
    localparam int SIZE    = 8;
    localparam int H       = SIZE / 2;
    localparam int NUM_ACT = 6;

    logic        clk, rst_n;
    logic [15:0] din_dp1, din_dp2;
    logic        din_dv, sync_in;
    logic [7:0]  din_chn;
    logic [15:0] dout_dq1, dout_dq2;
    logic        dout_dv, sync_out, err_sync;
    logic [7:0]  dout_chn;

    int vecs = 0;
    int errs = 0;

    prach_unreshape_ch #(.SIZE(SIZE), .NUM_ACTIVE(NUM_ACT)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv), .din_chn(din_chn),
        .sync_in(sync_in),
        .dout_dq1(dout_dq1), .dout_dq2(dout_dq2), .dout_dv(dout_dv), .dout_chn(dout_chn),
        .sync_out(sync_out), .err_sync(err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int f, input int base, input int k);
        return 16'(f * 4096 + base + k);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " dq1"}, dout_dq1, 16'h0);
        chk({tag, " dq2"}, dout_dq2, 16'h0);
        chk({tag, " dv"}, 16'(dout_dv), 16'h0);
        chk({tag, " chn"}, 16'(dout_chn), 16'h0);
        chk({tag, " sync_out"}, 16'(sync_out), 16'h0);
        chk({tag, " err_sync"}, 16'(err_sync), 16'h0);
    endtask

    // Feed n slots of frame f (sync on slot 0) and check each registered output slot.
    // cur_ok/prev_ok: whether frame f / f-1 were fed complete while locked.
    task automatic run_frame(input int f, input bit cur_ok, input bit prev_ok,
                             input bit kill2, input int n, input bit errf);
        for (int p = 0; p < n; p++) begin
            int j;
            bit src_ok, exp_dv;
            din_dp1 = (p < H) ? pat(f, 'h100, p) : pat(f, 'h120, p - H);
            din_dp2 = (p < H) ? pat(f, 'h110, p) : pat(f, 'h130, p - H);
            din_chn = 8'(p);
            sync_in = (p == 0);
            din_dv  = !(kill2 && p == 2);
            tick();
            j      = (p + H) % SIZE;
            src_ok = (j < H) ? cur_ok : prev_ok;
            exp_dv = src_ok && (j < NUM_ACT) && !(kill2 && j == 2) && !(errf && p >= 1 && p <= H);
            chk("chn", 16'(dout_chn), 16'(j));
            chk("err_sync", 16'(err_sync), 16'(errf && p == 0));
            chk("sync_out", 16'(sync_out), 16'(cur_ok && p == H));
            if (!(errf && p == 0)) begin
                chk("dv", 16'(dout_dv), 16'(exp_dv));
                if (src_ok) begin
                    if (j < H) begin
                        chk("dq1 phA", dout_dq1, pat(f, 'h100, j));
                        chk("dq2 phA", dout_dq2, pat(f, 'h120, j));
                    end else begin
                        chk("dq1 phB", dout_dq1, pat(f - 1, 'h110, j - H));
                        chk("dq2 phB", dout_dq2, pat(f - 1, 'h130, j - H));
                    end
                end
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_dp1 = 16'(i);
            din_dp2 = 16'(i + 'h55);
            din_chn = 8'(i % SIZE);
            din_dv  = 1'b1;
            sync_in = 1'b0;
            tick();
            chk("idle dv", 16'(dout_dv), 16'h0);
            chk("idle sync_out", 16'(sync_out), 16'h0);
            chk("idle err_sync", 16'(err_sync), 16'h0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        din_dp1 = '0;
        din_dp2 = '0;
        din_dv  = 1'b0;
        din_chn = '0;
        sync_in = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Stream without sync: must stay silent.
        idle(100);

        // Lock and stream; frame 3 drops dv on phase A slot 2.
        run_frame(1, 1'b1, 1'b0, 1'b0, SIZE, 1'b0);
        run_frame(2, 1'b1, 1'b1, 1'b0, SIZE, 1'b0);
        run_frame(3, 1'b1, 1'b1, 1'b1, SIZE, 1'b0);
        run_frame(4, 1'b1, 1'b1, 1'b0, SIZE, 1'b0);

        // Frame 5 cut short: sync arrives at position 5.
        run_frame(5, 1'b1, 1'b1, 1'b0, 5, 1'b0);
        run_frame(6, 1'b1, 1'b0, 1'b0, SIZE, 1'b1);
        run_frame(7, 1'b1, 1'b1, 1'b0, SIZE, 1'b0);

        // Mid-frame reset.
        run_frame(8, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        for (int i = 0; i < 3; i++) begin
            din_dp1 = 16'hbeef;
            din_dp2 = 16'hcafe;
            din_dv  = 1'b1;
            tick();
            chk_all_zero("in reset");
        end
        rst_n = 1'b1;
        idle(13);
        run_frame(9, 1'b1, 1'b0, 1'b0, SIZE, 1'b0);
        run_frame(10, 1'b1, 1'b1, 1'b0, SIZE, 1'b0);
        run_frame(11, 1'b1, 1'b1, 1'b0, SIZE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/prach_unreshape_ch.md
# prach_unreshape_ch

Inverse lane/channel corner-turn for the two-lane PRACH channel TDM stream. It takes frames in "per-half" lane order (lane 1 carries half 0, lane 2 carries half 1) and restores "per-channel-pair" lane order. It sits on the return side of the PRACH datapath, undoing the reshape stage. Sync tracking, channel renumbering, valid masking and sync-error detection are included.

## Interface

- SIZE, 8, channels per frame; power of two, 2..256. H = SIZE/2.
- NUM_ACTIVE, SIZE, channels with chn >= NUM_ACTIVE are output with dv = 0.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- din_dp1  in  16  lane 1 sample.
- din_dp2  in  16  lane 2 sample.
- din_dv  in  1  input slot valid.
- din_chn  in  8  input slot index 0..SIZE-1; informational only.
- sync_in  in  1  marks the first slot (phase A, k=0) of a frame.
- dout_dq1  out  16  lane 1 sample.
- dout_dq2  out  16  lane 2 sample.
- dout_dv  out  1  output slot valid.
- dout_chn  out  8  output slot index.
- sync_out  out  1  marks the first output slot of a frame.
- err_sync  out  1  one-cycle pulse on an unexpected sync.

## Operation

- The stream is continuous: one slot per clk, no back-pressure. A frame is SIZE slots: phase A (k=0..H-1), then phase B (k=0..H-1).
- Input order:
  - Phase A: dp1 = x0s0[k], dp2 = x1s0[k].
  - Phase B: dp1 = x0s1[k], dp2 = x1s1[k].
- Output order:
  - Phase A: dq1 = x0s0[k], dq2 = x0s1[k], dout_chn = k.
  - Phase B: dq1 = x1s0[k], dq2 = x1s1[k], dout_chn = H+k.
- Datapath:
  - D0 is an H-deep delay of dp2.
  - D1 is an H-deep delay whose input is dp1 during input phase A and D0 output during input phase B.
  - During input phase B: dq1 <= D1 out, dq2 <= dp1.
  - During input phase A: dq1 <= D1 out, dq2 <= D0 out.
  - All outputs are registered.
- State machine:
  - UNLOCKED (reset state): ignores the stream. dout_dv = 0 and sync_out = 0.
  - sync_in in UNLOCKED -> LOCKED, slot position = 0.
  - LOCKED: the position counter (0..SIZE-1) increments every cycle and wraps to 0.
  - sync_in in LOCKED with position == SIZE-1 on the previous cycle (expected boundary): no error.
  - sync_in in LOCKED anywhere else: the position is forced to 0, err_sync pulses on the next cycle, and blanking starts.
- Blanking: after an error resync at cycle t, dout_dv = 0 for output cycles t+2 .. t+H+1.
- dout_dv = din_dv delayed H+1 AND (locked, delayed H+1) AND (dout_chn < NUM_ACTIVE) AND NOT blanking.
- sync_out = sync_in delayed H+1, gated by locked. It is also emitted on an error resync.
- din_chn is not used for sequencing; only sync_in defines the frame position.

## Timing

- Latency: H+1 cycles from an input slot to the output slot it opens. sync_in at cycle t gives sync_out at t+H+1.
- Output phase A data is available from the current input frame. Output phase B data spans into the next input frame's phase A slots, so streaming must continue.
- Reset values: dout_dq1 = 0, dout_dq2 = 0, dout_dv = 0, dout_chn = 0, sync_out = 0, err_sync = 0, state = UNLOCKED, position = 0. Delay lines are not reset.
- Reset mid-frame: all outputs go to 0 immediately. After release the block waits in UNLOCKED for the next sync_in.
- sync_in on two consecutive cycles: the second is an error, giving err_sync and a restart at position 0.
- SIZE = 2 (H = 1): latency is 2 cycles and delays are 1 deep. Behaviour is otherwise identical.
- dout_chn is always driven from the position counter, even when dout_dv = 0.

## Test plan

- SIZE=8, locked, continuous frames, sync at t0:
  - Input: A dp1 = 0x0100+k, dp2 = 0x0110+k; B dp1 = 0x0120+k, dp2 = 0x0130+k.
  - Required: from t0+5, A gives dq1 = 0x0100+k, dq2 = 0x0120+k, chn k; B gives dq1 = 0x0110+k, dq2 = 0x0130+k, chn 4+k; sync_out at t0+5.
- Round trip prach_reshape_ch -> prach_unreshape_ch (SIZE=8), random data, 20 frames -> output equals input, delayed 10 cycles, with dv and chn preserved.
- Stream running with no sync_in after reset -> dout_dv and sync_out stay 0 for 100 cycles. First sync at t -> dout_dv = 1 from t+5.
- Locked; sync_in at position 5 (cycle t) ->
  - err_sync = 1 at t+1 only;
  - dout_dv = 0 for t+2..t+5;
  - sync_out at t+5 with chn 0 and correct data afterward.
- NUM_ACTIVE=6 plus din_dv = 0 on input phase A slot k=2 ->
  - dout_dv = 0 on chn 6, 7 every frame;
  - dout_dv = 0 on the output slot fed from that input slot (chn 2, H+1 = 5 cycles later).
- rst_n low for 3 cycles mid-frame -> all outputs 0 during reset. After release: no dv until a new sync, then nominal behaviour with no err_sync.
